// File: rtl/v810_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : v810_pkg
//  Description : Shared constants for the V810 memory-access unit: the
//                execution-unit access-size encoding carried on EDBC and a
//                helper that classifies a size as a full 32-bit access.
//  Revision    : 1.0 - initial release
// ============================================================================
package v810_pkg;

    // EDBC access-size encoding
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;   // behaves exactly like SZ_WORD

    // True for accesses that need all 32 bits (word and the reserved code).
    function automatic logic is_word(input logic [1:0] sz);
        return (sz == SZ_WORD) || (sz == SZ_RSVD);
    endfunction

endpackage : v810_pkg
`default_nettype wire

// File: rtl/v810_mem.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : v810_mem
//  Description : Execution-unit to external-bus bridge for the V810 core.
//                Runs IDLE -> T1 -> T2 bus cycles with wait states, splits a
//                32-bit access into two halfword cycles when the device
//                reports a 16-bit port, and returns read data with a
//                one-cycle EDACK completion pulse.
//  Revision    : 1.0 - initial release
//
//  Ports
//    CLK     in   1   clock, rising edge
//    RES     in   1   asynchronous active-high reset
//    CE      in   1   clock enable; nothing changes while low
//    EDA     in  32   execution-unit address
//    EDD_O   in  32   write data, already lane-aligned
//    EDD_I   out 32   read data to execution unit (held until next read)
//    EDBC    in   2   access size (byte/half/word/reserved=word)
//    EDBE    in   4   active-high byte enables
//    EDWR    in   1   1 = write, 0 = read
//    EDREQ   in   1   request, held with operands until EDACK
//    EDACK   out  1   one-cycle completion pulse
//    A       out 32   bus address (word aligned)
//    D_I     in  32   bus read data
//    D_O     out 32   bus write data
//    BEn     out  4   active-low byte enables
//    DAn     out  1   data strobe, low in T2
//    MRQn    out  1   memory request, low in T1 and T2
//    RW      out  1   1 = read, 0 = write
//    BCYSTn  out  1   bus-cycle start, low in T1 (first T2 under bypass)
//    READYn  in   1   low ends the current T2
//    SZRQn   in   1   low together with READYn = 16-bit device
// ============================================================================
module v810_mem
    import v810_pkg::*;
(
    input  logic        CLK,
    input  logic        RES,
    input  logic        CE,
    input  logic [31:0] EDA,
    input  logic [31:0] EDD_O,
    output logic [31:0] EDD_I,
    input  logic [1:0]  EDBC,
    input  logic [3:0]  EDBE,
    input  logic        EDWR,
    input  logic        EDREQ,
    output logic        EDACK,
    output logic [31:0] A,
    input  logic [31:0] D_I,
    output logic [31:0] D_O,
    output logic [3:0]  BEn,
    output logic        DAn,
    output logic        MRQn,
    output logic        RW,
    output logic        BCYSTn,
    input  logic        READYn,
    input  logic        SZRQn
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_T1   = 2'd1,
        S_T2   = 2'd2
    } state_t;

    // Debug control, written hierarchically by a bench: 1 = start cycles in T2.
    logic dbg_bypass = 1'b0;

    state_t      r_state;
    logic        r_hi;        // second halfword cycle of a split word access
    logic [15:0] r_lo;        // low half captured from the first split cycle
    logic        r_edack;
    logic [31:0] r_eddi;
    logic [31:0] r_a;
    logic [31:0] r_dout;
    logic [3:0]  r_be_n;
    logic        r_da_n;
    logic        r_mrq_n;
    logic        r_rw;
    logic        r_bcyst_n;

    logic        w_word;
    logic        w_split;
    logic        w_launch;
    logic        w_launch_hi;
    logic [31:0] w_dout_lo;
    logic [31:0] w_dout_hi;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_word = is_word(EDBC);

    // A finished T2 on a 16-bit port still owes the upper half of a word.
    assign w_split = !SZRQn && w_word && !r_hi;

    // A new bus cycle starts either from IDLE on a fresh request (never in
    // the EDACK cycle, where the old request is still visible) or straight
    // out of T2 for the upper half of a split word.
    assign w_launch_hi = (r_state == S_T2);
    assign w_launch    = ((r_state == S_IDLE) && EDREQ && !r_edack) ||
                         ((r_state == S_T2) && !READYn && w_split);

    // A 16-bit device only sees D[15:0], so the upper halfword is mirrored
    // down when the low lanes are unused or when the upper half is being sent.
    assign w_dout_hi = {EDD_O[31:16], EDD_O[31:16]};
    assign w_dout_lo = (EDBE[1:0] == 2'b00) ? w_dout_hi : EDD_O;

    always_comb begin
        w_rdata = D_I;
        if (!SZRQn) begin
            if (w_word)
                w_rdata = {D_I[15:0], r_lo};
            else if (EDBE[1:0] == 2'b00)
                w_rdata = {D_I[15:0], D_I[15:0]};
        end
    end

    // The bus address is always word aligned, so EDA[1:0] has no consumer.
    assign w_unused = ^EDA[1:0];

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            r_state   <= S_IDLE;
            r_hi      <= 1'b0;
            r_lo      <= 16'h0000;
            r_edack   <= 1'b0;
            r_eddi    <= 32'h0000_0000;
            r_a       <= 32'h0000_0000;
            r_dout    <= 32'h0000_0000;
            r_be_n    <= 4'b1111;
            r_da_n    <= 1'b1;
            r_mrq_n   <= 1'b1;
            r_rw      <= 1'b1;
            r_bcyst_n <= 1'b1;
        end else if (CE) begin
            r_edack <= 1'b0;
            if (w_launch) begin
                if (w_launch_hi) begin
                    r_lo <= D_I[15:0];
                    r_hi <= 1'b1;
                end
                r_state   <= dbg_bypass ? S_T2 : S_T1;
                r_a       <= {EDA[31:2], 2'b00};
                r_rw      <= ~EDWR;
                r_mrq_n   <= 1'b0;
                r_bcyst_n <= 1'b0;
                r_da_n    <= ~dbg_bypass;
                r_be_n    <= w_launch_hi ? 4'b0011 : ~EDBE;
                r_dout    <= w_launch_hi ? w_dout_hi : w_dout_lo;
            end else begin
                case (r_state)
                    S_T1: begin
                        r_state   <= S_T2;
                        r_bcyst_n <= 1'b1;
                        r_da_n    <= 1'b0;
                    end
                    S_T2: begin
                        // Start strobe lasts one cycle even under bypass.
                        r_bcyst_n <= 1'b1;
                        if (!READYn) begin
                            r_state <= S_IDLE;
                            r_hi    <= 1'b0;
                            r_edack <= 1'b1;
                            if (!r_rw)
                                r_eddi <= r_eddi;
                            else
                                r_eddi <= w_rdata;
                            r_mrq_n <= 1'b1;
                            r_da_n  <= 1'b1;
                            r_rw    <= 1'b1;
                            r_be_n  <= 4'b1111;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign EDACK  = r_edack;
    assign EDD_I  = r_eddi;
    assign A      = r_a;
    assign D_O    = r_dout;
    assign BEn    = r_be_n;
    assign DAn    = r_da_n;
    assign MRQn   = r_mrq_n;
    assign RW     = r_rw;
    assign BCYSTn = r_bcyst_n;

endmodule : v810_mem
`default_nettype wire

// File: tb/tb_v810_mem.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_v810_mem
//  Description : Self-checking bench for v810_mem. Directed accesses for the
//                documented scenarios, a reset-abort case, then randomized
//                accesses against a transaction-level model of the bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_v810_mem;

    logic        CLK = 1'b0;
    logic        RES;
    logic        CE;
    logic [31:0] EDA, EDD_O, EDD_I, A, D_I, D_O;
    logic [1:0]  EDBC;
    logic [3:0]  EDBE, BEn;
    logic        EDWR, EDREQ, EDACK, DAn, MRQn, RW, BCYSTn, READYn, SZRQn;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] exp_eddi;

    v810_mem dut (
        .CLK(CLK), .RES(RES), .CE(CE), .EDA(EDA), .EDD_O(EDD_O),
        .EDD_I(EDD_I), .EDBC(EDBC), .EDBE(EDBE), .EDWR(EDWR),
        .EDREQ(EDREQ), .EDACK(EDACK), .A(A), .D_I(D_I), .D_O(D_O),
        .BEn(BEn), .DAn(DAn), .MRQn(MRQn), .RW(RW), .BCYSTn(BCYSTn),
        .READYn(READYn), .SZRQn(SZRQn)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Bus outputs while a cycle is in progress (T1 or T2).
    task automatic bus_out(input string tag, input logic ex_bcyst, input logic ex_da,
                           input logic [3:0] ex_be, input logic [31:0] ex_a,
                           input logic ex_rw, input logic [31:0] ex_do);
        chk1({tag, ".MRQn"},   MRQn,   1'b0);
        chk1({tag, ".BCYSTn"}, BCYSTn, ex_bcyst);
        chk1({tag, ".DAn"},    DAn,    ex_da);
        chk1({tag, ".RW"},     RW,     ex_rw);
        chk1({tag, ".EDACK"},  EDACK,  1'b0);
        chk({tag, ".BEn"}, {28'h0, BEn}, {28'h0, ex_be});
        chk({tag, ".A"},   A,   ex_a);
        if (!ex_rw) chk({tag, ".D_O"}, D_O, ex_do);
    endtask

    // One complete execution-unit access. d0/d1 are the bus read data of the
    // first and (if split) second bus cycle. The model derives everything
    // from the access description alone.
    task automatic do_access(input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] d0, input logic [31:0] d1,
                             input logic [1:0] bc, input logic [3:0] be,
                             input logic wr, input logic is16, input logic byp,
                             input int waits, input logic stall);
        logic        word;
        int          nb;
        logic [31:0] ex_a, ex_do, rd;
        logic [3:0]  ex_be;
        word = bc[1];
        nb   = (is16 && word) ? 2 : 1;
        ex_a = {addr[31:2], 2'b00};
        dut.dbg_bypass = byp;
        EDA = addr; EDD_O = wd; EDBC = bc; EDBE = be; EDWR = wr; EDREQ = 1'b1;
        for (int b = 0; b < nb; b++) begin
            ex_be = (b == 1) ? 4'b0011 : ~be;
            ex_do = (b == 1 || be[1:0] == 2'b00) ? {wd[31:16], wd[31:16]} : wd;
            if (!byp) begin
                step();
                bus_out("T1", 1'b0, 1'b1, ex_be, ex_a, ~wr, ex_do);
                READYn = 1'b1;
                if (stall) begin
                    CE = 1'b0;
                    repeat (2) begin
                        step();
                        bus_out("T1stall", 1'b0, 1'b1, ex_be, ex_a, ~wr, ex_do);
                    end
                    CE = 1'b1;
                end
            end
            for (int k = 0; k <= waits; k++) begin
                step();
                bus_out("T2", (byp && k == 0) ? 1'b0 : 1'b1, 1'b0, ex_be, ex_a, ~wr, ex_do);
                READYn = (k == waits) ? 1'b0 : 1'b1;
                // SZRQn is don't-care while waiting, so it is randomized there.
                SZRQn  = (k == waits) ? ~is16 : 1'($urandom);
                D_I    = (k == waits) ? ((b == 1) ? d1 : d0) : $urandom;
            end
        end
        if (!wr) begin
            if (!is16)                   rd = d0;
            else if (word)               rd = {d1[15:0], d0[15:0]};
            else if (be[1:0] == 2'b00)   rd = {d0[15:0], d0[15:0]};
            else                         rd = d0;
            exp_eddi = rd;
        end
        step();
        chk1("done.EDACK",  EDACK,  1'b1);
        chk("done.EDD_I",   EDD_I,  exp_eddi);
        chk1("done.MRQn",   MRQn,   1'b1);
        chk1("done.DAn",    DAn,    1'b1);
        chk1("done.BCYSTn", BCYSTn, 1'b1);
        chk1("done.RW",     RW,     1'b1);
        chk("done.BEn", {28'h0, BEn}, 32'hF);
        chk("done.A", A, ex_a);
        EDREQ = 1'b0; READYn = 1'b1; SZRQn = 1'b1;
        step();
        chk1("after.EDACK", EDACK, 1'b0);
        chk1("after.MRQn",  MRQn,  1'b1);
    endtask

    initial begin
        RES = 1'b1; CE = 1'b1; EDA = '0; EDD_O = '0; EDBC = 2'd2; EDBE = 4'hF;
        EDWR = 1'b0; EDREQ = 1'b0; D_I = '0; READYn = 1'b1; SZRQn = 1'b1;
        exp_eddi = 32'h0;
        step(); step();
        chk1("rst.MRQn",   MRQn,   1'b1);
        chk1("rst.DAn",    DAn,    1'b1);
        chk1("rst.BCYSTn", BCYSTn, 1'b1);
        chk1("rst.RW",     RW,     1'b1);
        chk1("rst.EDACK",  EDACK,  1'b0);
        chk("rst.BEn", {28'h0, BEn}, 32'hF);
        chk("rst.A", A, 32'h0);
        chk("rst.D_O", D_O, 32'h0);
        chk("rst.EDD_I", EDD_I, 32'h0);
        RES = 1'b0;
        step();

        // 32-bit zero-wait read
        do_access(32'h4, 32'h0, 32'h1234_5678, 32'h0, 2'd2, 4'hF, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        // 32-bit write, one wait state
        do_access(32'h100, 32'hDEAD_BEEF, 32'h0, 32'h0, 2'd2, 4'hF, 1'b1, 1'b0, 1'b0, 1, 1'b0);
        // word read from 16-bit device: split into two halfword cycles
        do_access(32'h202, 32'h0, 32'hAAAA_5678, 32'hBBBB_1234, 2'd2, 4'hF, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        // halfword write on upper lanes to 16-bit device
        do_access(32'h300, 32'hABCD_0000, 32'h0, 32'h0, 2'd1, 4'b1100, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        // bypass read
        do_access(32'h40, 32'h0, 32'h0BAD_F00D, 32'h0, 2'd2, 4'hF, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        // clock-enable stall in T1, reserved size code on a 16-bit port
        do_access(32'h80, 32'h0, 32'h1111_2222, 32'h3333_4444, 2'd3, 4'hF, 1'b0, 1'b1, 1'b0, 1, 1'b1);

        // Reset during a waited T2 abandons the access
        dut.dbg_bypass = 1'b0;
        EDA = 32'h500; EDWR = 1'b0; EDBC = 2'd2; EDBE = 4'hF; EDREQ = 1'b1; READYn = 1'b1;
        step(); step();
        chk1("wait.DAn", DAn, 1'b0);
        #2 RES = 1'b1; EDREQ = 1'b0;
        #1;
        chk1("ares.MRQn",   MRQn,   1'b1);
        chk1("ares.DAn",    DAn,    1'b1);
        chk1("ares.BCYSTn", BCYSTn, 1'b1);
        chk("ares.A", A, 32'h0);
        RES = 1'b0;
        exp_eddi = 32'h0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk1("ares.noack", EDACK, 1'b0);
        end
        do_access(32'h504, 32'h0, 32'hCAFE_0001, 32'h0, 2'd2, 4'hF, 1'b0, 1'b0, 1'b0, 0, 1'b0);

        // Randomized accesses
        for (int n = 0; n < 40; n++) begin
            do_access($urandom, $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)),
                      4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      int'($urandom_range(0, 2)), 1'($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_v810_mem
`default_nettype wire

// File: doc/v810_mem.md
V810_MEM -- requirements
Module: v810_mem

Interface
REQ-001 Timing: one clock; reset is asynchronous and active-high.
REQ-002 Parameters: none. Debug variable dbg_bypass, default 0, hierarchically writable by a bench; 1 = skip the T1 state.
REQ-003 Ports, one per line (name, direction, width, meaning):
- CLK  in  1  clock, all state on rising edge.
- RES  in  1  asynchronous active-high reset.
- CE  in  1  clock enable; state advances only when CE=1.
- EDA  in  32  execution-unit address.
- EDD_O  in  32  write data, already lane-aligned.
- EDD_I  out  32  read data to execution unit.
- EDBC  in  2  size: 0 byte, 1 halfword, 2 word, 3 reserved (treated as word).
- EDBE  in  4  active-high byte enables.
- EDWR  in  1  1 = write, 0 = read.
- EDREQ  in  1  access request, held with operands until EDACK.
- EDACK  out  1  completion pulse.
- A  out  32  bus address.
- D_I  in  32  bus read data.
- D_O  out  32  bus write data.
- BEn  out  4  active-low byte enables.
- DAn  out  1  data strobe, low in T2.
- MRQn  out  1  memory request, low in T1 and T2.
- RW  out  1  1 = read, 0 = write.
- BCYSTn  out  1  bus cycle start, low in T1 only.
- READYn  in  1  low = bus cycle ends this T2.
- SZRQn  in  1  low with READYn low = 16-bit device.

Function
REQ-004 States IDLE, T1, T2; flag HI marks the second halfword cycle.
REQ-005 IDLE with EDREQ=1 goes to T1, or to T2 if dbg_bypass=1. EDREQ is ignored in the cycle EDACK=1.
REQ-006 T1 always goes to T2.
REQ-007 T2 sampling READYn=1 stays in T2 (wait state), with all outputs stable.
REQ-008 T2 sampling READYn=0 completes the bus cycle. Then:
- If SZRQn=0, EDBC is word and HI=0: latch D_I[15:0] as the low half, set HI, and start a new bus cycle (T1, or T2 if bypass) at the same address.
- Otherwise: register EDACK=1 for exactly one CE cycle, update EDD_I, clear HI, return to IDLE.
REQ-009 In T1 and T2: A={EDA[31:2],2'b00}; RW=~EDWR; MRQn=0. BEn=~EDBE, except BEn=0011 when HI=1. BCYSTn=0 only in T1, or in the first T2 cycle under bypass. DAn=0 only in T2.
REQ-010 Write data:
- D_O is valid whenever MRQn=0 and RW=0.
- D_O=EDD_O, except D_O[15:0]=EDD_O[31:16] when EDBE[1:0]=00 or HI=1.
REQ-011 Read data:
- SZRQn=1: EDD_I=D_I.
- SZRQn=0, word: EDD_I={D_I[15:0], latched low half}.
- SZRQn=0, EDBE[1:0]=00: EDD_I={D_I[15:0],D_I[15:0]}.
- SZRQn=0, other: EDD_I=D_I.
REQ-012 EDD_I holds its value until the next read completes. EDACK is also issued for writes.
REQ-013 In IDLE: MRQn, DAn and BCYSTn are 1; BEn=1111; RW=1; A and D_O hold their last value.
REQ-014 SZRQn is ignored unless READYn=0 in T2. CE=0 freezes state and outputs.

Reset
REQ-015 RES=1 immediately forces:
- state IDLE, HI=0, EDACK=0
- MRQn=1, DAn=1, BCYSTn=1, RW=1, BEn=1111
- A=0, D_O=0, EDD_I=0
REQ-016 Reset mid-cycle abandons the access without an EDACK; the first request after release begins at T1.

Structure
REQ-017 Package v810_pkg holds the EDBC size encoding constants; the state enum stays local.
REQ-018 No sub-module; a single module of about 150-250 lines.

Verification
REQ-019 32-bit, 0-wait read, EDA=0x4, EDBE=F, D_I=0x12345678 -> cycle 1 BCYSTn=MRQn=0, RW=1; cycle 2 DAn=0; cycle 3 EDACK=1, EDD_I=0x12345678.
REQ-020 32-bit write with 1 wait state, EDD_O=0xDEADBEEF -> T2 lasts 2 cycles, D_O stable, BEn=0000, EDACK in cycle 4.
REQ-021 16-bit word read, D_I[15:0]=0x5678 then 0x1234 -> two bus cycles, second with BEn=0011 and same A; EDD_I=0x12345678.
REQ-022 16-bit halfword write, EDBE=1100, EDD_O=0xABCD0000 -> single cycle, BEn=0011, D_O[15:0]=0xABCD.
REQ-023 dbg_bypass=1 read -> BCYSTn=DAn=0 in the first cycle; EDACK in cycle 2.
REQ-024 RES pulsed during a waited T2 -> strobes go high asynchronously and no EDACK occurs; the next request starts with T1.
